// File: rtl/fifo_wr_producer_pkg.sv
// Shared types and constants for the FIFO write-side burst producer.
// Pattern mode is selected by FIFO_WR_PRODUCER_LFSR_EN (LFSR) or left undefined (increment).
package fifo_wr_producer_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned LEN_W_DEF  = 8;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] ZERO_SEED_REPL = 16'h0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_wr_producer_pattern_gen.sv
// Combinational next-word function shared by the write producer and read-side checker.
// FIFO_WR_PRODUCER_LFSR_EN selects the LFSR step; otherwise a wrapping increment.
module pattern_gen
    import fifo_wr_producer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] cur,
    output logic [DATA_W-1:0] next_word_c
);

    always_comb begin
`ifdef FIFO_WR_PRODUCER_LFSR_EN
        next_word_c = {cur[DATA_W-2:0], ^(cur & DATA_W'(LFSR_TAPS))};
`else
        next_word_c = cur + DATA_W'(1);
`endif
    end

endmodule

// File: rtl/fifo_wr_producer.sv
// Burst traffic source for the dual-clock FIFO write port (clk_1 domain).
// FIFO_WR_PRODUCER_LFSR_EN: LFSR pattern with zero-seed replacement; default: increment pattern.
module fifo_wr_producer
    import fifo_wr_producer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] seed,
    input  logic              buffer_full,
    output logic              data_1_en,
    output logic [DATA_W-1:0] data_1,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_sent
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [LEN_W-1:0]   words_d;
    logic [DATA_W-1:0]  data_d;
    logic [DATA_W-1:0]  next_word_c;
    logic [DATA_W-1:0]  seed_eff_c;

    pattern_gen #(.DATA_W(DATA_W)) u_pattern_gen (
        .cur         (data_1),
        .next_word_c (next_word_c)
    );

    // Write gate is combinational so a full FIFO is never written.
    always_comb begin
        data_1_en = (state_q == RUN) && !buffer_full;
    end

    always_comb begin
        seed_eff_c = seed;
`ifdef FIFO_WR_PRODUCER_LFSR_EN
        if (seed == '0) seed_eff_c = DATA_W'(ZERO_SEED_REPL);
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        words_d     = words_sent;
        data_d      = data_1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = length;
                    data_d      = seed_eff_c;
                    words_d     = '0;
                    state_d     = (length != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (data_1_en) begin
                    data_d      = next_word_c;
                    remaining_d = remaining_q - LEN_W'(1);
                    words_d     = words_sent + LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            data_1      <= '0;
            words_sent  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            data_1      <= data_d;
            words_sent  <= words_d;
            busy        <= (state_d == RUN);
            done        <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_fifo_wr_producer.sv
// Self-checking bench for fifo_wr_producer: directed vector table, reset/ignore sequences, random bursts.
module tb_fifo_wr_producer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  length;
    logic [15:0] seed;
    logic        buffer_full;
    logic        data_1_en;
    logic [15:0] data_1;
    logic        busy;
    logic        done;
    logic [7:0]  words_sent;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_producer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .length      (length),
        .seed        (seed),
        .buffer_full (buffer_full),
        .data_1_en   (data_1_en),
        .data_1      (data_1),
        .busy        (busy),
        .done        (done),
        .words_sent  (words_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] seed;
        logic [7:0]  len;
        logic [31:0] stall_mask;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pattern model straight from the word-sequence rules.
    function automatic logic [15:0] ref_next(input logic [15:0] w);
`ifdef FIFO_WR_PRODUCER_LFSR_EN
        return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
`else
        return w + 16'd1;
`endif
    endfunction

    function automatic logic [15:0] ref_seed(input logic [15:0] s);
`ifdef FIFO_WR_PRODUCER_LFSR_EN
        return (s == 16'h0000) ? 16'h0001 : s;
`else
        return s;
`endif
    endfunction

    // One burst: drives start, applies stalls (mask and/or random percentage), checks every cycle.
    // lat = cycle offset from the accepting edge at which done is seen.
    task automatic run_burst(input logic [15:0] s, input logic [7:0] n, input logic [31:0] mask,
                             input int pct, output int lat, output logic [15:0] first_w,
                             output logic [15:0] last_w);
        logic [15:0] exp_w;
        int  k;
        int  cyc;
        bit  fin;
        bit  bf;
        exp_w   = ref_seed(s);
        k       = 0;
        cyc     = 0;
        fin     = 0;
        lat     = -1;
        first_w = '0;
        last_w  = '0;
        @(negedge clk);
        start       = 1'b1;
        length      = n;
        seed        = s;
        buffer_full = 1'b0;
        @(posedge clk); #1;
        while (!fin && cyc < 1200) begin
            cyc++;
            bf = 1'b0;
            if (k < int'(n)) begin
                if (cyc <= 32 && mask[cyc-1]) bf = 1'b1;
                if (pct > 0 && int'($urandom_range(99)) < pct) bf = 1'b1;
                start  = 1'($urandom_range(1));
                length = 8'($urandom);
                seed   = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            buffer_full = bf;
            @(negedge clk);
            if (k < int'(n)) begin
                chk("busy_run", int'(busy), 1);
                chk("done_early", int'(done), 0);
                chk("words_sent_run", int'(words_sent), k);
                chk("wr_en", int'(data_1_en), int'(!bf));
                if (data_1_en) begin
                    chk("data", int'(data_1), int'(exp_w));
                    if (k == 0) first_w = data_1;
                    last_w = data_1;
                    exp_w  = ref_next(exp_w);
                    k++;
                end
            end else begin
                chk("done_pulse", int'(done), 1);
                chk("busy_done", int'(busy), 0);
                chk("wr_en_done", int'(data_1_en), 0);
                chk("words_sent_final", int'(words_sent), int'(n));
                lat = cyc;
                fin = 1;
            end
            @(posedge clk); #1;
        end
        start       = 1'b0;
        buffer_full = 1'b0;
        if (!fin) chk("burst_timeout", 0, 1);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("busy_idle", int'(busy), 0);
        chk("words_sent_hold", int'(words_sent), int'(n));
    endtask

    vec_t vecs[$];

    initial begin
        int          lat;
        logic [15:0] fw, lw;
        int          nw;

        rst         = 1'b0;
        start       = 1'b0;
        length      = '0;
        seed        = '0;
        buffer_full = 1'b0;

`ifdef FIFO_WR_PRODUCER_LFSR_EN
        vecs.push_back('{16'h0000, 8'd2, 32'h0, 16'h0001, 16'h0002, 3});
        vecs.push_back('{16'h8000, 8'd2, 32'h0, 16'h8000, 16'h0001, 3});
        vecs.push_back('{16'h0001, 8'd3, 32'h2, 16'h0001, 16'h0004, 5});
`else
        vecs.push_back('{16'h00FE, 8'd4,   32'h0, 16'h00FE, 16'h0101, 5});
        vecs.push_back('{16'hFFFE, 8'd3,   32'h0, 16'hFFFE, 16'h0000, 4});
        vecs.push_back('{16'h0100, 8'd5,   32'hE, 16'h0100, 16'h0104, 9});
        vecs.push_back('{16'hABCD, 8'd0,   32'h0, 16'h0000, 16'h0000, 1});
        vecs.push_back('{16'h0000, 8'd1,   32'h1, 16'h0000, 16'h0000, 3});
        vecs.push_back('{16'h1234, 8'd255, 32'h0, 16'h1234, 16'h1332, 256});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", int'(data_1_en), 0);
        chk("rst_data", int'(data_1), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_words", int'(words_sent), 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_burst(vecs[i].seed, vecs[i].len, vecs[i].stall_mask, 0, lat, fw, lw);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_first", i), int'(fw), int'(vecs[i].exp_first));
            chk($sformatf("vec%0d_last", i), int'(lw), int'(vecs[i].exp_last));
        end

        // Reset in the middle of a 10-word burst, after 4 writes.
        @(negedge clk);
        start  = 1'b1;
        length = 8'd10;
        seed   = 16'h0040;
        @(posedge clk); #1;
        start = 1'b0;
        nw = 0;
        repeat (4) begin
            @(negedge clk);
            if (data_1_en) nw++;
            @(posedge clk); #1;
        end
        chk("mid_writes_before_rst", nw, 4);
        rst = 1'b0;
        #1;
        chk("mid_rst_en", int'(data_1_en), 0);
        chk("mid_rst_data", int'(data_1), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_words", int'(words_sent), 0);
        nw = 0;
        repeat (3) begin
            @(negedge clk);
            if (data_1_en) nw++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (data_1_en || busy || done) nw++;
        end
        chk("mid_rst_no_activity", nw, 0);
        chk("mid_rst_words_idle", int'(words_sent), 0);

        // Randomised bursts with random backpressure and stray start pulses.
        for (int r = 0; r < 25; r++) begin
            logic [15:0] rs;
            logic [7:0]  rl;
            int          stalls_ok;
            rs = 16'($urandom);
            if (r % 5 == 0) rs = 16'hFFFF - 16'($urandom_range(3));
            rl = 8'($urandom_range(0, 24));
            run_burst(rs, rl, 32'h0, 35, lat, fw, lw);
            stalls_ok = (lat >= int'(rl) + 1) ? 1 : 0;
            chk("rand_latency_min", stalls_ok, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_producer.md
# fifo_wr_producer

Write-side traffic source for the dual-clock FIFO wrapper. On a start command it generates a burst of `length` 16-bit words from a seed and pushes them into the FIFO write port (`data_1`/`data_1_en`), stalling while the FIFO reports `buffer_full`. It lives in the `clk_1` domain, is clocked by the DCM-generated write clock, and is the producer counterpart of the wrapper's read side.

## Interface
Parameters:
- `DATA_W`, 16, word width; must match the wrapper data width.
- `LEN_W`, 8, width of burst length and sent-word counter.

Ports:
- `clk`, input, 1, write-domain clock (connect to `clk_1`); all logic on rising edge.
- `rst`, input, 1, reset, asynchronous, active-low.
- `start`, input, 1, burst request; sampled only in IDLE.
- `length`, input, LEN_W, words in burst; captured with `start`.
- `seed`, input, DATA_W, first word of burst; captured with `start`.
- `buffer_full`, input, 1, FIFO full flag (write-domain synchronous).
- `data_1_en`, output, 1, FIFO write enable.
- `data_1`, output, DATA_W, FIFO write data.
- `busy`, output, 1, high while in RUN.
- `done`, output, 1, one-cycle pulse at burst end.
- `words_sent`, output, LEN_W, words written in current/last burst.

## Operation
- FSM states IDLE, RUN, DONE.
- IDLE: on `start`=1, capture `length` into remaining counter, load `data_1` with `seed`, clear `words_sent`; go RUN if `length`≠0, else DONE.
- RUN: `data_1_en` = RUN && !`buffer_full` (combinational gate, never writes into a full FIFO). Each cycle `data_1_en`=1: `data_1` advances to next pattern word, remaining decrements, `words_sent` increments. When the write of the last word occurs (remaining==1 and `data_1_en`=1), go DONE.
- While `buffer_full`=1 in RUN: hold `data_1`, counters and state; `data_1_en`=0.
- DONE: `done`=1 for exactly one cycle, then IDLE. `words_sent` holds its final value until the next accepted `start`.
- `start` in RUN or DONE is ignored (no queuing).
- Counter arithmetic: unsigned, LEN_W bits; maximum burst 2^LEN_W−1 words.
- Reset (any time, including mid-burst): state IDLE, `data_1_en`=0, `data_1`=0, `busy`=0, `done`=0, `words_sent`=0; partial burst abandoned, no further writes.

## Timing
- `start` accepted at edge T → RUN from T+1; `data_1`=seed and `busy`=1 in cycle T+1; first write in T+1 if not full.
- Without stalls, an N-word burst writes in cycles T+1…T+N; `done`=1 and `busy`=0 in T+N+1; IDLE at T+N+2, next `start` accepted there.
- `length`=0: no writes; `done`=1 in T+1.
- Each stall cycle extends the burst by exactly one cycle.
- `buffer_full` rising in the same cycle as would-be write: no write that cycle, word retried.

## Configuration
- `FIFO_WR_PRODUCER_LFSR_EN` defined: next word = 16-bit Fibonacci LFSR step, polynomial x^16+x^14+x^13+x^11+1 (shift left, feedback into bit 0); a captured seed of 0 is replaced by 16'h0001.
- Undefined: next word = previous + 1, wrapping 16'hFFFF → 16'h0000; seed used as given, including 0.

## Structure
- Package `fifo_wr_producer_pkg`: state enum (IDLE, RUN, DONE), DATA_W/LEN_W defaults, LFSR tap mask constant, zero-seed replacement constant.
- One sub-module `pattern_gen`: combinational next-word function (LFSR or increment per macro), shared later by the read-side checker.

## Test plan
- Reset mid-burst: length 10, assert `rst`=0 after 4 writes → all outputs 0 immediately, no further `data_1_en`, idle after release.
- Increment mode, seed 16'h00FE, length 4, full tied 0 → writes 00FE, 00FF, 0100, 0101 in 4 consecutive cycles; `done` one cycle later; `words_sent`=4.
- Wrap: seed 16'hFFFE, length 3 → FFFE, FFFF, 0000.
- Backpressure: length 5, `buffer_full`=1 for cycles 2–4 of burst → no `data_1_en` while full, data held, 5 writes total, `done` delayed 3 cycles.
- `length`=0 → zero writes, `done` in cycle after start; `start` during RUN ignored (`words_sent` unchanged).
- LFSR build, seed 0 → first word 0001, second 0002; end-to-end through wrapper with `clk_2` slower: read side receives identical sequence, no loss.
